// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED blinker: channel modes and
// the prescaler divide-ratio helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: latches mode/period on a write and counts time-base ticks
// to drive a steady, blinking or one-shot LED.
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W      = 16,
  parameter int RST_PERIOD = 500
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             tick_i,
  input  logic             we_i,
  input  logic [1:0]       mode_i,
  input  logic [PER_W-1:0] period_i,
  output logic             led_o,
  output logic             busy_o
);

  mode_e            mode_q, mode_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             last;

  assign last = (cnt_q == per_q - 1'b1);

  always_comb begin
    mode_d = mode_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    // A write takes priority over a coincident tick, which is then dropped.
    if (we_i) begin
      mode_d = mode_e'(mode_i);
      per_d  = (period_i == '0) ? PER_W'(1) : period_i;
      cnt_d  = '0;
      led_d  = (mode_e'(mode_i) != MODE_OFF);
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          led_d = 1'b0;
          cnt_d = '0;
        end
        MODE_ON: begin
          led_d = 1'b1;
          cnt_d = '0;
        end
        MODE_BLINK: if (tick_i) begin
          if (last) begin
            led_d = ~led_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_ONESHOT: if (tick_i) begin
          if (last) begin
            led_d  = 1'b0;
            cnt_d  = '0;
            mode_d = MODE_OFF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mode_q <= MODE_OFF;
      per_q  <= PER_W'(RST_PERIOD);
      cnt_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = (mode_q == MODE_ONESHOT);

endmodule

// File: rtl/led_blinker_multi.sv
// Board-level multi-channel LED driver: free-running prescaler producing a
// slow tick, a config write decoder and N_CH independent LED channels.
module led_blinker_multi
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int N_CH       = 4,
  parameter int PER_W      = 16,
  parameter int RST_PERIOD = 500
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [PER_W-1:0] cfg_period,
  output logic [N_CH-1:0]  LED,
  output logic [N_CH-1:0]  busy,
  output logic             tick
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0 || N_CH < 1 || N_CH > 16) begin : g_param_chk
    $error("led_blinker_multi: CLK_HZ/TICK_HZ must be an integer >= 2 and N_CH in 1..16");
  end

  logic [PRE_W-1:0] pre_q, pre_d;

  assign tick  = (pre_q == PRE_W'(DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) pre_q <= '0;
    else          pre_q <= pre_d;
  end

  logic [N_CH-1:0] we_ch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign we_ch[i] = cfg_we && (cfg_ch == 4'(i));

    led_channel #(
      .PER_W      (PER_W),
      .RST_PERIOD (RST_PERIOD)
    ) u_ch (
      .gclk     (CLOCK_50),
      .grst_n   (RESET_N),
      .tick_i   (tick),
      .we_i     (we_ch[i]),
      .mode_i   (cfg_mode),
      .period_i (cfg_period),
      .led_o    (LED[i]),
      .busy_o   (busy[i])
    );
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Randomized + directed bench; reference model tracks ticks elapsed since each
// channel's last write and derives LED/busy arithmetically from that.
module tb_led_blinker_multi;

  localparam int CLK_HZ = 100, TICK_HZ = 10, DIV = 10;
  localparam int N_CH = 4, PER_W = 16, RST_PERIOD = 3;

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N  = 1'b0;
  logic             cfg_we   = 1'b0;
  logic [3:0]       cfg_ch   = '0;
  logic [1:0]       cfg_mode = '0;
  logic [PER_W-1:0] cfg_period = '0;
  logic [N_CH-1:0]  LED, busy;
  logic             tick;

  led_blinker_multi #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .N_CH(N_CH), .PER_W(PER_W), .RST_PERIOD(RST_PERIOD)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .LED(LED), .busy(busy), .tick(tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles since reset release, and per channel the mode,
  // effective period and number of ticks seen since its last write.
  int cyc;
  int m_mode[N_CH];
  int m_per[N_CH];
  int m_n[N_CH];

  function automatic logic [N_CH-1:0] exp_led();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) begin
      case (m_mode[c])
        1:       r[c] = 1'b1;
        2:       r[c] = ((m_n[c] / m_per[c]) % 2) == 0;
        3:       r[c] = m_n[c] < m_per[c];
        default: r[c] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_busy();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = (m_mode[c] == 3) && (m_n[c] < m_per[c]);
    return r;
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < N_CH; c++) begin
      m_mode[c] = 0; m_per[c] = RST_PERIOD; m_n[c] = 0;
    end
  endtask

  // One clock: optionally present a write, advance model, compare after edge.
  task automatic cycle(input logic we, input int ch, input int mode, input int per);
    logic tick_now;
    cfg_we = we; cfg_ch = 4'(ch); cfg_mode = 2'(mode); cfg_period = PER_W'(per);
    tick_now = (cyc % DIV) == DIV - 1;
    for (int c = 0; c < N_CH; c++) begin
      if (we && ch == c) begin
        m_mode[c] = mode; m_per[c] = (per == 0) ? 1 : per; m_n[c] = 0;
      end else if (tick_now) begin
        m_n[c]++;
      end
    end
    @(posedge CLOCK_50); #1;
    cyc++;
    cfg_we = 1'b0;
    chk("led",  32'(LED),  32'(exp_led()));
    chk("busy", 32'(busy), 32'(exp_busy()));
    chk("tick", 32'(tick), 32'((cyc % DIV) == DIV - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #2;
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Idle after reset: LEDs dark, tick every DIV cycles starting at cycle 9.
    idle(200);

    // BLINK period 3 on ch1.
    cycle(1'b1, 1, 2, 3);
    chk("blink_first", 32'(LED[1]), 32'h1);
    idle(120);

    // ONESHOT period 4 on ch2, then long idle for no further activity.
    cycle(1'b1, 2, 3, 4);
    chk("oneshot_busy", 32'(busy[2]), 32'h1);
    idle(200);
    chk("oneshot_done", 32'(LED[2]), 32'h0);

    // ONESHOT ch0 period 5, rewrite after 3 ticks extends lit time.
    cycle(1'b1, 0, 3, 5);
    while ((cyc % DIV) != DIV - 1) idle(1);
    idle(21);
    cycle(1'b1, 0, 3, 5);
    chk("retrig_busy", 32'(busy[0]), 32'h1);
    idle(80);

    // Write coincident with a tick: that tick is dropped.
    while ((cyc % DIV) != DIV - 1) idle(1);
    cycle(1'b1, 3, 2, 2);
    chk("coinc_led", 32'(LED[3]), 32'h1);
    idle(40);

    // Out-of-range channel ignored; period 0 behaves as 1.
    cycle(1'b1, 7, 1, 9);
    cycle(1'b1, 1, 2, 0);
    idle(45);

    // Async reset mid-blink.
    do_reset();
    idle(25);

    // Randomized writes with random gaps.
    for (int k = 0; k < 300; k++) begin
      cycle(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 5)));
      idle(int'($urandom_range(0, 25)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
